// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: the MIPS funct codes it
// decodes and the sequencing FSM state type.
package muldiv_pkg;

  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply and divide.
// Multiply: {acc,low} holds partial product / remaining multiplier bits;
//   add opnd when the multiplier LSB is set, then shift the pair right.
// Divide:   acc holds the partial remainder, low the dividend bits being
//   shifted out and quotient bits being shifted in (restoring algorithm).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] low_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;

  // Single add/shift or trial-subtract step, selected by operation type.
  always_comb begin
    mul_sum   = {1'b0, acc_i} + (low_i[0] ? {1'b0, opnd_i} : '0);
    div_shift = {acc_i, low_i[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_i};
    // A successful subtraction always leaves a remainder below the divisor,
    // so both upper bits are zero exactly when the trial subtract succeeds.
    div_ge    = ~|div_diff[WIDTH+1:WIDTH];
    if (is_div_i) begin
      if (div_ge) begin
        acc_o = div_diff[WIDTH-1:0];
        low_o = {low_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = div_shift[WIDTH-1:0];
        low_o = {low_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = mul_sum[WIDTH:1];
      low_o = {mul_sum[0], low_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for start; mthi/mtlo and illegal funct handled here
//   PREP  | take operand magnitudes, record result signs, load counter
//   CALC  | one radix-2 step per cycle, WIDTH cycles
//   FIX   | apply sign correction, write HI/LO
//   DONE  | done pulse (div_by_zero qualifies it), back to IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       function_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               is_signed_q, is_signed_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_acc, step_low;
  logic [2*WIDTH-1:0] prod_neg;

  // Magnitudes of the latched operands; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  assign a_mag    = (is_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag    = (is_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod_neg = -{acc_q, low_q};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .low_i    (low_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .low_o    (step_low)
  );

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    low_d       = low_q;
    opnd_d      = opnd_q;
    a_d         = a_q;
    b_d         = b_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    dbz_d       = dbz_q;
    ill_d       = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (function_code)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              state_d     = ST_PREP;
              a_d         = op_a;
              b_d         = op_b;
              is_div_d    = function_code[1];
              is_signed_d = ~function_code[0];
              dbz_d       = 1'b0;
            end
            FN_MTHI: hi_d  = op_a;
            FN_MTLO: lo_d  = op_a;
            default: ill_d = 1'b1;
          endcase
        end
      end

      ST_PREP: begin
        acc_d    = '0;
        cnt_d    = CNT_W'(WIDTH);
        neg_lo_d = is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi_d = is_signed_q & a_q[WIDTH-1];
        if (is_div_q) begin
          if (b_q == '0) begin
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            opnd_d  = b_mag;
            low_d   = a_mag;
            state_d = ST_CALC;
          end
        end else begin
          opnd_d  = a_mag;
          low_d   = b_mag;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d = step_acc;
        low_d = step_low;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -low_q : low_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : {acc_q, low_q};
        end
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      low_q       <= '0;
      opnd_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      low_q       <= low_d;
      opnd_q      <= opnd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      dbz_q       <= dbz_d;
      ill_q       <= ill_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = (state_q == ST_DONE) & dbz_q;
  assign illegal_op  = ill_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   function_code;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_by_zero, illegal_op;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .function_code (function_code),
    .op_a          (op_a),
    .op_b          (op_b),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .illegal_op    (illegal_op),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ill;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every done or illegal_op pulse pops one expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b0 && (done === 1'b1 || illegal_op === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'b0, done, illegal_op}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_kind"}, {63'b0, illegal_op}, {63'b0, mon_e.is_ill});
        chk({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
        chk({mon_e.name, "_hi"}, {32'b0, hi}, {32'b0, mon_e.hi});
        chk({mon_e.name, "_lo"}, {32'b0, lo}, {32'b0, mon_e.lo});
        if (mon_e.is_ill)
          chk({mon_e.name, "_busy"}, {63'b0, busy}, 64'd0);
        else
          chk({mon_e.name, "_dbz"}, {63'b0, div_by_zero}, {63'b0, mon_e.dbz});
      end
    end
  end

  // Issue one request at a negedge with the DUT idle; returns at the first
  // negedge where the DUT is idle again. poke drives a stray start mid-op.
  task automatic issue(string name, logic [5:0] f, logic [31:0] a, logic [31:0] b, bit poke);
    exp_t e;
    int c0, k, sa, sbv;
    logic [63:0] p;
    bit push;
    push     = 1'b1;
    e.name   = name;
    e.is_ill = 1'b0;
    e.dbz    = 1'b0;
    c0       = cyc;
    e.cyc    = c0 + W + 3;
    function_code = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    case (f)
      F_MULT: begin
        sa = int'(a); sbv = int'(b);
        p = 64'(longint'(sa) * longint'(sbv));
        {m_hi, m_lo} = p;
      end
      F_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p;
      end
      F_DIV: begin
        sa = int'(a); sbv = int'(b);
        if (b == 0) begin
          e.dbz = 1'b1; e.cyc = c0 + 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'h0;
        end else begin
          m_lo = 32'(sa / sbv);
          m_hi = 32'(sa % sbv);
        end
      end
      F_DIVU: begin
        if (b == 0) begin
          e.dbz = 1'b1; e.cyc = c0 + 2;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      F_MTHI: begin m_hi = a; push = 1'b0; end
      F_MTLO: begin m_lo = a; push = 1'b0; end
      default: begin e.is_ill = 1'b1; e.cyc = c0 + 1; end
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    function_code = 6'($urandom);
    if (!push) begin
      chk({name, "_hi"}, {32'b0, hi}, {32'b0, m_hi});
      chk({name, "_lo"}, {32'b0, lo}, {32'b0, m_lo});
      chk({name, "_busy"}, {63'b0, busy}, 64'd0);
    end
    k = 0;
    while (busy === 1'b1 && k < 60) begin
      if (poke && cyc == c0 + 5) begin
        start = 1'b1;
        function_code = F_MTHI;
        op_a = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    if (k >= 60) chk({name, "_timeout_busy"}, {63'b0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] f;
    int sel;
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fsel;
    reset = 1'b1;
    start = 1'b0;
    function_code = '0;
    op_a = '0;
    op_b = '0;
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    chk("rst_ill", {63'b0, illegal_op}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    issue("multu_max_x2", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    issue("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    issue("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("mthi", F_MTHI, 32'h0000_1234, 32'h0, 1'b0);
    issue("mtlo", F_MTLO, 32'h0000_5678, 32'h0, 1'b0);
    issue("divu_by0", F_DIVU, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue("illegal_100100", 6'b100100, 32'h1, 32'h2, 1'b0);
    issue("div_pos_neg", F_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: fsel = F_MULT;
        1: fsel = F_MULTU;
        2: fsel = F_DIV;
        3: fsel = F_DIVU;
        4: fsel = F_MTHI;
        5: fsel = F_MTLO;
        6: fsel = F_DIV;
        default: begin
          fsel = 6'($urandom);
          while (fsel inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO})
            fsel = 6'($urandom);
        end
      endcase
      issue($sformatf("rand%0d_f%b", i, fsel), fsel, pick_val(), pick_val(), 1'($urandom));
    end

    // Reset in the middle of a multu, after an ignored second start.
    issue("mthi_pre_rst", F_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
    function_code = F_MULTU;
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    function_code = F_MULT;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midop_rst_busy", {63'b0, busy}, 64'd0);
    chk("midop_rst_hi", {32'b0, hi}, 64'd0);
    chk("midop_rst_lo", {32'b0, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO register width (>= 4, even).
REQ-002 Parameter: CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe, sampled only in IDLE.
REQ-006 function_code  input  6  MIPS R-type funct field selecting the operation.
REQ-007 op_a  input  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source).
REQ-008 op_b  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 busy  output  1  high while any multi-cycle operation is in flight.
REQ-010 done  output  1  one-cycle pulse marking HI/LO result valid.
REQ-011 div_by_zero  output  1  high with done when a divide had op_b == 0.
REQ-012 illegal_op  output  1  one-cycle pulse when start is accepted with an unsupported funct.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers, continuously readable (mfhi/mflo).

Function
REQ-014 Supported funct codes: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011.
REQ-015 FSM states: IDLE, PREP, CALC, FIX, DONE; busy = (state != IDLE).
REQ-016 IDLE + start + mult/multu/div/divu -> PREP; operands, funct and signedness latched at that edge.
REQ-017 PREP: signed ops take operand magnitudes and record result signs; counter loaded with WIDTH; -> CALC.
REQ-018 PREP with div/divu and op_b == 0 -> DONE directly; hi/lo unchanged; div_by_zero = 1 during DONE.
REQ-019 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide); counter decrements; -> FIX after exactly WIDTH cycles.
REQ-020 FIX: apply two's-complement sign correction; -> DONE; hi/lo written at the edge entering DONE.
REQ-021 DONE: done = 1 for exactly one cycle; -> IDLE.
REQ-022 Latency: start high in cycle 0 -> done high in cycle WIDTH+3 (cycle 35 for WIDTH=32); divide-by-zero -> cycle 2.
REQ-023 Multiply: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per funct.
REQ-024 Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-025 Signed overflow (min / -1): lo = most-negative value, hi = 0, no flag.
REQ-026 mthi/mtlo with start in IDLE: hi (resp. lo) <= op_a at next edge; single cycle; busy, done stay 0.
REQ-027 start while busy: ignored, no state, flag or register change.
REQ-028 Unsupported funct with start in IDLE: illegal_op pulses next cycle; state stays IDLE; hi/lo unchanged.
REQ-029 Operand inputs may change after the accepting edge without affecting the result.
REQ-030 New start is accepted in the cycle after DONE (back-to-back operations allowed).

Reset
REQ-031 reset asserted: state = IDLE, hi = lo = 0, busy = done = div_by_zero = illegal_op = 0, counter = 0, immediately and independent of clk.
REQ-032 Reset mid-operation abandons the operation; no done pulse follows its release.

Structure
REQ-033 Package muldiv_pkg holds funct-code constants and the FSM state typedef/encoding.
REQ-034 One sub-module muldiv_step: combinational single-iteration add/subtract-shift datapath, instantiated once.

Verification (WIDTH=32)
REQ-035 mult a=FFFFFFFD, b=00000007 -> done cycle 35, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 multu a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE.
REQ-037 div a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-038 divu b=0 with hi/lo preloaded 1234/5678 via mthi/mtlo -> done cycle 2, div_by_zero=1, hi=1234, lo=5678.
REQ-039 multu started, second start at cycle 5 (ignored), reset at cycle 10 -> busy=0, hi=lo=0, no done within 40 cycles.
REQ-040 start with funct 100100 -> illegal_op pulses cycle 1, busy stays 0, hi/lo unchanged.
